alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 4-bit ALU. Each requester presents an operand pair and opcode over a valid/ready handshake. The block grants one requester at a time (round-robin on contention), latches its operands, drives the single ALU instance, and returns the registered result tagged with the requester id over a valid/ready response channel. It sits between the two operation sources and the one ALU.

---
 rtl/alu_ctrl_pkg.sv | 15 +
 rtl/alu_arbiter_alu.sv | 22 ++
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU arbiter slice.
package alu_ctrl_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 4-bit ALU: AND/OR/XOR/ADD (carry discarded).
// Zero latency, no flow control.
module ALU
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] inA,
    input  logic [3:0] inB,
    input  logic [1:0] op,
    output logic [3:0] ans
);

    always_comb begin
        ans = 4'd0;
        case (op)
            OP_AND:  ans = inA & inB;
            OP_OR:   ans = inA | inB;
            OP_XOR:  ans = inA ^ inB;
            default: ans = inA + inB;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for the shared ALU; response 1 cycle after accept.
// One operation in flight; requests stall (req_ready=0) until the response handshakes.
module alu_arbiter
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_id,
    output logic       busy
);

    state_t     state_q;
    logic       last_id_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] op_q;
    logic       id_q;
    logic       rsp_valid_q;
    logic [3:0] rsp_data_q;
    logic       rsp_id_q;

    logic       grant_id;
    logic       accept;
    logic [3:0] alu_ans;

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_id = ~last_id_q;
        end
    end

    assign req_ready = (state_q == IDLE) ? ((grant_id ? 2'b10 : 2'b01) & req_valid) : 2'b00;
    assign accept    = |req_ready;

    ALU u_alu (
        .inA (a_q),
        .inB (b_q),
        .op  (op_q),
        .ans (alu_ans)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_id_q   <= 1'b1;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            op_q        <= 2'd0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'd0;
            rsp_id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q       <= grant_id ? req1_a  : req0_a;
                        b_q       <= grant_id ? req1_b  : req0_b;
                        op_q      <= grant_id ? req1_op : req0_op;
                        id_q      <= grant_id;
                        last_id_q <= grant_id;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_ans;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized transactions.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_id;
    logic       busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic m_last = 1'b1;  // model: requester served most recently

    alu_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int r;
        case (op)
            2'd0:    r = int'(a & b);
            2'd1:    r = int'(a | b);
            2'd2:    r = int'(a ^ b);
            default: r = (int'(a) + int'(b)) % 16;
        endcase
        return r[3:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        req_valid = 2'($urandom_range(0, 3));
        req0_a    = 4'($urandom_range(0, 15));
        req0_b    = 4'($urandom_range(0, 15));
        req0_op   = 2'($urandom_range(0, 3));
        req1_a    = 4'($urandom_range(0, 15));
        req1_b    = 4'($urandom_range(0, 15));
        req1_op   = 2'($urandom_range(0, 3));
    endtask

    // One complete transaction starting in IDLE (sampled 1 time unit after an edge).
    task automatic serve(input logic [1:0] vld,
                         input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] o0,
                         input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] o1,
                         input int stall);
        logic       g;
        logic [3:0] exp_d;
        req_valid = vld;
        req0_a = a0; req0_b = b0; req0_op = o0;
        req1_a = a1; req1_b = b1; req1_op = o1;
        rsp_ready = (stall == 0);
        #1;
        g     = (vld == 2'b11) ? ~m_last : vld[1];
        exp_d = g ? alu_ref(a1, b1, o1) : alu_ref(a0, b0, o0);
        check("grant", 8'(req_ready), g ? 8'd2 : 8'd1);
        check("idle_busy", 8'(busy), 8'd0);
        step();
        m_last = g;
        scramble_inputs();
        #1;
        check("exec_ready", 8'(req_ready), 8'd0);
        check("exec_busy", 8'(busy), 8'd1);
        check("exec_rsp_valid", 8'(rsp_valid), 8'd0);
        step();
        check("rsp_valid", 8'(rsp_valid), 8'd1);
        check("rsp_data", 8'(rsp_data), 8'(exp_d));
        check("rsp_id", 8'(rsp_id), 8'(g));
        check("resp_busy", 8'(busy), 8'd1);
        for (int i = 0; i < stall; i++) begin
            rsp_ready = 1'b0;
            scramble_inputs();
            #1;
            check("stall_ready", 8'(req_ready), 8'd0);
            step();
            check("stall_valid", 8'(rsp_valid), 8'd1);
            check("stall_data", 8'(rsp_data), 8'(exp_d));
            check("stall_id", 8'(rsp_id), 8'(g));
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        step();
        check("done_valid", 8'(rsp_valid), 8'd0);
        check("done_busy", 8'(busy), 8'd0);
    endtask

    task automatic reset_pulse_checks(input string where);
        #2;
        rst_n = 1'b0;
        #1;
        check({where, "_rst_valid"}, 8'(rsp_valid), 8'd0);
        check({where, "_rst_data"}, 8'(rsp_data), 8'd0);
        check({where, "_rst_id"}, 8'(rsp_id), 8'd0);
        check({where, "_rst_busy"}, 8'(busy), 8'd0);
        #2;
        rst_n = 1'b1;
        m_last = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check({where, "_dropped"}, 8'(rsp_valid), 8'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready = 1'b1;
        #1;
        check("reset_valid", 8'(rsp_valid), 8'd0);
        check("reset_data", 8'(rsp_data), 8'd0);
        check("reset_id", 8'(rsp_id), 8'd0);
        check("reset_busy", 8'(busy), 8'd0);
        check("reset_ready", 8'(req_ready), 8'd0);
        #12;
        rst_n = 1'b1;
        step();

        // Tie after reset: 0 (AND=8), then 1 (XOR=6), then 0 again.
        for (int i = 0; i < 3; i++) begin
            serve(2'b11, 4'd12, 4'd10, 2'b00, 4'd12, 4'd10, 2'b10, 0);
        end
        check("rr_last", 8'(rsp_id), 8'd0);
        check("rr_data", 8'(rsp_data), 8'd8);

        serve(2'b01, 4'd2, 4'd3, 2'b11, 4'd0, 4'd0, 2'b00, 0);
        check("single_data", 8'(rsp_data), 8'd5);
        serve(2'b10, 4'd0, 4'd0, 2'b00, 4'd15, 4'd1, 2'b11, 0);
        check("wrap_data", 8'(rsp_data), 8'd0);
        check("wrap_id", 8'(rsp_id), 8'd1);
        serve(2'b01, 4'd5, 4'd10, 2'b01, 4'd0, 4'd0, 2'b00, 0);
        check("or_data", 8'(rsp_data), 8'd15);

        // Backpressure, then the waiting request is taken in the first IDLE cycle.
        serve(2'b10, 4'd3, 4'd9, 2'b10, 4'd7, 4'd6, 2'b11, 5);
        serve(2'b01, 4'd9, 4'd9, 2'b11, 4'd1, 4'd1, 2'b00, 0);

        // Withdrawn request during EXEC is never accepted.
        req_valid = 2'b01; req0_a = 4'd4; req0_b = 4'd4; req0_op = 2'b11;
        rsp_ready = 1'b1;
        #1;
        check("wd_grant", 8'(req_ready), 8'd1);
        step();
        m_last = 1'b0;
        req_valid = 2'b10;
        #1;
        check("wd_exec_ready", 8'(req_ready), 8'd0);
        step();
        req_valid = 2'b00;
        check("wd_rsp_data", 8'(rsp_data), 8'd8);
        step();
        for (int i = 0; i < 3; i++) begin
            check("wd_idle_busy", 8'(busy), 8'd0);
            check("wd_idle_valid", 8'(rsp_valid), 8'd0);
            step();
        end

        // Reset during EXEC.
        req_valid = 2'b01; req0_a = 4'd2; req0_b = 4'd3; req0_op = 2'b11;
        #1;
        step();
        m_last = 1'b0;
        check("pre_rst_exec_busy", 8'(busy), 8'd1);
        reset_pulse_checks("exec");
        serve(2'b11, 4'd6, 4'd3, 2'b10, 4'd1, 4'd1, 2'b11, 0);

        // Reset during RESP with a held response.
        req_valid = 2'b10; req1_a = 4'd7; req1_b = 4'd1; req1_op = 2'b11;
        rsp_ready = 1'b0;
        #1;
        step();
        m_last = 1'b1;
        req_valid = 2'b00;
        step();
        check("pre_rst_resp_valid", 8'(rsp_valid), 8'd1);
        check("pre_rst_resp_data", 8'(rsp_data), 8'd8);
        rsp_ready = 1'b1;
        rsp_ready = 1'b0;
        reset_pulse_checks("resp");
        rsp_ready = 1'b1;
        serve(2'b11, 4'd1, 4'd2, 2'b01, 4'd5, 4'd5, 2'b00, 0);
        check("post_rst_tie_id", 8'(rsp_id), 8'd0);

        // Randomized transactions against the model.
        for (int t = 0; t < 40; t++) begin
            serve(2'($urandom_range(1, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
